// File: rtl/div_sequencer_if.sv
// div_sequencer_if: bus between the EX-stage division sequencer (master)
// and the multi-cycle divider (slave).
//
// Handshake: the master raises div_start for exactly one cycle with
// div_signed/div_opdata1/div_opdata2 already valid. The operands stay
// stable until the divider answers. The divider raises div_ready for one
// cycle with div_result = {remainder, quotient} valid in that same cycle.
// div_annul is a one-cycle abort that cancels the operation in flight.
// An abort is never issued in the same cycle as a start.
interface div_sequencer_if #(
    parameter int DATA_W = 32
);
    logic                  div_start;
    logic                  div_annul;
    logic                  div_signed;
    logic [DATA_W-1:0]     div_opdata1;
    logic [DATA_W-1:0]     div_opdata2;
    logic                  div_ready;
    logic [2*DATA_W-1:0]   div_result;

    modport master (
        output div_start,
        output div_annul,
        output div_signed,
        output div_opdata1,
        output div_opdata2,
        input  div_ready,
        input  div_result
    );

    modport slave (
        input  div_start,
        input  div_annul,
        input  div_signed,
        input  div_opdata1,
        input  div_opdata2,
        output div_ready,
        output div_result
    );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: EX-stage sequencer for DIV/DIVU on a multi-cycle divider.
// It decodes the op, latches the operands, starts the divider and stalls
// the pipeline until {hi,lo} is ready. It then presents the result until
// EX is allowed to advance. A flush abandons the operation.
//
// Optional build macro: DIV_ZERO_FASTPATH_EN
//   When defined, a zero divisor skips the divider entirely.
//   The ZERO state then produces {dividend, all-ones} in one cycle.
//   When undefined, a zero divisor goes to the divider like any other.
//
// state_dbg exposes the FSM encoding for checkers and debug.

`ifndef EXE_DIV_OP
`define EXE_DIV_OP  8'b00011010
`endif
`ifndef EXE_DIVU_OP
`define EXE_DIVU_OP 8'b00011011
`endif

module div_sequencer #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      op,
    input  logic [DATA_W-1:0]    opdata1,
    input  logic [DATA_W-1:0]    opdata2,
    input  logic                 flush,
    input  logic                 ex_stall,
    div_sequencer_if.master      div_bus,
    output logic                 stall_req,
    output logic                 result_valid,
    output logic [2*DATA_W-1:0]  result,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
`ifdef DIV_ZERO_FASTPATH_EN
        ,
        ZERO = 2'd3
`endif
    } state_t;

    state_t state;

    logic is_div;
    logic is_signed_op;

    // Op decode: only the two divide ops engage the sequencer.
    always_comb begin
        is_signed_op = (op == OP_W'(`EXE_DIV_OP));
        is_div       = is_signed_op || (op == OP_W'(`EXE_DIVU_OP));
    end

    // Stall request. It rises with the op in IDLE so that EX holds from the
    // first cycle. It drops in DONE so that the result can leave EX.
    always_comb begin
        stall_req = 1'b0;
        if (state == IDLE && is_div && !flush) stall_req = 1'b1;
        if (state == RUN)                      stall_req = 1'b1;
`ifdef DIV_ZERO_FASTPATH_EN
        if (state == ZERO)                     stall_req = 1'b1;
`endif
    end

    // Status views of the FSM.
    always_comb begin
        busy      = (state != IDLE);
        state_dbg = state;
    end

    // Main FSM. div_start and div_annul are registered one-cycle pulses.
    // The result register changes only when a division completes, so a flushed
    // operation leaves the previous result in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            div_bus.div_start   <= 1'b0;
            div_bus.div_annul   <= 1'b0;
            div_bus.div_signed  <= 1'b0;
            div_bus.div_opdata1 <= '0;
            div_bus.div_opdata2 <= '0;
            result_valid        <= 1'b0;
            result              <= '0;
        end else begin
            div_bus.div_start <= 1'b0;
            div_bus.div_annul <= 1'b0;
            case (state)
                IDLE: begin
                    // div_ready is ignored here, and so is any non-divide op.
                    if (is_div && !flush) begin
                        div_bus.div_opdata1 <= opdata1;
                        div_bus.div_opdata2 <= opdata2;
                        div_bus.div_signed  <= is_signed_op;
`ifdef DIV_ZERO_FASTPATH_EN
                        if (opdata2 == '0) begin
                            state <= ZERO;
                        end else begin
                            div_bus.div_start <= 1'b1;
                            state             <= RUN;
                        end
`else
                        div_bus.div_start <= 1'b1;
                        state             <= RUN;
`endif
                    end
                end
                RUN: begin
                    // A flush beats a div_ready that arrives in the same cycle.
                    if (flush) begin
                        div_bus.div_annul <= 1'b1;
                        state             <= IDLE;
                    end else if (div_bus.div_ready) begin
                        result       <= div_bus.div_result;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
`ifdef DIV_ZERO_FASTPATH_EN
                ZERO: begin
                    // The divider was never started, so nothing needs annulling.
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        result       <= {div_bus.div_opdata1, {DATA_W{1'b1}}};
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
`endif
                DONE: begin
                    // The divide op is still on op here. It must not restart.
                    if (flush || !ex_stall) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed test of div_sequencer. The bench plays the divider
// and the pipeline. Every check is made on the falling edge, +1 time unit after
// that edge. Cycle k is the interval between rising edge k and rising edge k+1.

`ifndef EXE_DIV_OP
`define EXE_DIV_OP  8'b00011010
`endif
`ifndef EXE_DIVU_OP
`define EXE_DIVU_OP 8'b00011011
`endif

module tb_div_sequencer;
    localparam int DATA_W = 32;
    localparam int OP_W   = 8;
    localparam logic [OP_W-1:0] OP_DIV  = `EXE_DIV_OP;
    localparam logic [OP_W-1:0] OP_DIVU = `EXE_DIVU_OP;
    localparam logic [OP_W-1:0] OP_NOP  = 8'h00;

    logic                 clk;
    logic                 rst_n;
    logic [OP_W-1:0]      op;
    logic [DATA_W-1:0]    opdata1;
    logic [DATA_W-1:0]    opdata2;
    logic                 flush;
    logic                 ex_stall;
    logic                 stall_req;
    logic                 result_valid;
    logic [2*DATA_W-1:0]  result;
    logic                 busy;
    logic [1:0]           state_dbg;

    logic [2*DATA_W-1:0]  last_result;
    int vectors;
    int miscompares;

    div_sequencer_if #(.DATA_W(DATA_W)) div_bus ();

    div_sequencer #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .opdata1      (opdata1),
        .opdata2      (opdata2),
        .flush        (flush),
        .ex_stall     (ex_stall),
        .div_bus      (div_bus.master),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .result       (result),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next check point, which is the falling edge plus 1.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op = OP_NOP; opdata1 = '0; opdata2 = '0;
        flush = 1'b0; ex_stall = 1'b0;
        div_bus.div_ready = 1'b0; div_bus.div_result = '0;
        tick(); tick();
        vectors++;
        if ({div_bus.div_start, div_bus.div_annul, div_bus.div_signed, stall_req, result_valid, busy} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000000",
                     {div_bus.div_start, div_bus.div_annul, div_bus.div_signed, stall_req, result_valid, busy});
        end
        vectors++;
        if ({div_bus.div_opdata1, div_bus.div_opdata2, result} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h want zeros", div_bus.div_opdata1, div_bus.div_opdata2, result);
        end
        last_result = '0;
        rst_n = 1'b1;
        tick();
    endtask

    // Directed test 1: DIVU 100/7. The divider answers in cycle 33.
    task automatic test_divu_basic();
        op = OP_DIVU; opdata1 = 32'd100; opdata2 = 32'd7; #1;
        vectors++;
        if (stall_req !== 1'b1 || div_bus.div_start !== 1'b0) begin
            miscompares++;
            $display("FAIL divu_c0: stall_req=%b div_start=%b want 1 0", stall_req, div_bus.div_start);
        end
        for (int c = 1; c <= 33; c++) begin
            tick();
            if (c == 33) begin
                div_bus.div_ready = 1'b1; div_bus.div_result = {32'd2, 32'd14}; #1;
            end
            vectors++;
            if (stall_req !== 1'b1 || div_bus.div_start !== (c == 1) || result_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL divu_run_c%0d: stall_req=%b div_start=%b result_valid=%b want 1 %b 0",
                         c, stall_req, div_bus.div_start, result_valid, (c == 1));
            end
            if (c == 1) begin
                vectors++;
                if (div_bus.div_signed !== 1'b0 || div_bus.div_opdata1 !== 32'd100 || div_bus.div_opdata2 !== 32'd7) begin
                    miscompares++;
                    $display("FAIL divu_operands: signed=%b op1=%0d op2=%0d want 0 100 7",
                             div_bus.div_signed, div_bus.div_opdata1, div_bus.div_opdata2);
                end
            end
        end
        tick(); // cycle 34
        div_bus.div_ready = 1'b0; #1;
        last_result = {32'd2, 32'd14};
        vectors++;
        if (result_valid !== 1'b1 || result !== last_result || stall_req !== 1'b0) begin
            miscompares++;
            $display("FAIL divu_done: valid=%b result=%h stall_req=%b want 1 %h 0",
                     result_valid, result, stall_req, last_result);
        end
        tick(); // cycle 35
        op = OP_NOP; #1;
        vectors++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || div_bus.div_start !== 1'b0) begin
            miscompares++;
            $display("FAIL divu_idle: valid=%b busy=%b start=%b want 0 0 0", result_valid, busy, div_bus.div_start);
        end
    endtask

    // Directed test 2: DIV -7/2. The result is passed through unchanged.
    task automatic test_div_signed();
        op = OP_DIV; opdata1 = 32'hFFFF_FFF9; opdata2 = 32'd2;
        tick(); // cycle 1
        vectors++;
        if (div_bus.div_start !== 1'b1 || div_bus.div_signed !== 1'b1 || div_bus.div_opdata1 !== 32'hFFFF_FFF9) begin
            miscompares++;
            $display("FAIL div_signed_start: start=%b signed=%b op1=%h want 1 1 fffffff9",
                     div_bus.div_start, div_bus.div_signed, div_bus.div_opdata1);
        end
        tick(); tick(); tick(); // cycle 4
        div_bus.div_ready = 1'b1; div_bus.div_result = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tick(); // cycle 5
        div_bus.div_ready = 1'b0; #1;
        last_result = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vectors++;
        if (result_valid !== 1'b1 || result !== last_result) begin
            miscompares++;
            $display("FAIL div_signed_result: valid=%b result=%h want 1 %h", result_valid, result, last_result);
        end
        tick();
        op = OP_NOP;
    endtask

    // Directed test 3: a flush in RUN at cycle 10. A later div_ready is then ignored.
    task automatic test_flush_run();
        op = OP_DIV; opdata1 = 32'd20; opdata2 = 32'd3;
        for (int c = 1; c <= 10; c++) tick();
        flush = 1'b1; op = OP_NOP;
        tick(); // cycle 11
        flush = 1'b0; #1;
        vectors++;
        if (div_bus.div_annul !== 1'b1 || div_bus.div_start !== 1'b0 || busy !== 1'b0 || stall_req !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_annul: annul=%b start=%b busy=%b stall=%b want 1 0 0 0",
                     div_bus.div_annul, div_bus.div_start, busy, stall_req);
        end
        tick(); // cycle 12
        vectors++;
        if (div_bus.div_annul !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_annul_pulse: annul=%b want 0", div_bus.div_annul);
        end
        div_bus.div_ready = 1'b1; div_bus.div_result = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        div_bus.div_ready = 1'b0; #1;
        vectors++;
        if (result_valid !== 1'b0 || result !== last_result || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_late_ready: valid=%b result=%h busy=%b want 0 %h 0",
                     result_valid, result, busy, last_result);
        end
    endtask

    // Directed test 4: DONE is held by ex_stall for 3 cycles.
    task automatic test_ex_stall_hold();
        op = OP_DIVU; opdata1 = 32'd50; opdata2 = 32'd6;
        tick(); tick(); tick(); // cycle 3
        div_bus.div_ready = 1'b1; div_bus.div_result = {32'd2, 32'd8}; ex_stall = 1'b1;
        last_result = {32'd2, 32'd8};
        tick(); // cycle 4, the first cycle in DONE
        div_bus.div_ready = 1'b0; #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (result_valid !== 1'b1 || stall_req !== 1'b0 || div_bus.div_start !== 1'b0 || result !== last_result) begin
                miscompares++;
                $display("FAIL exstall_hold_%0d: valid=%b stall=%b start=%b result=%h want 1 0 0 %h",
                         k, result_valid, stall_req, div_bus.div_start, result, last_result);
            end
            tick();
        end
        ex_stall = 1'b0; #1;
        vectors++;
        if (result_valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL exstall_release: valid=%b busy=%b want 1 1", result_valid, busy);
        end
        tick();
        op = OP_NOP; #1;
        vectors++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || div_bus.div_start !== 1'b0) begin
            miscompares++;
            $display("FAIL exstall_idle: valid=%b busy=%b start=%b want 0 0 0", result_valid, busy, div_bus.div_start);
        end
    endtask

    // Directed test 5: DIV 5/0.
    task automatic test_zero_divisor();
        op = OP_DIV; opdata1 = 32'd5; opdata2 = 32'd0;
        tick(); // cycle 1
`ifdef DIV_ZERO_FASTPATH_EN
        vectors++;
        if (div_bus.div_start !== 1'b0 || busy !== 1'b1 || stall_req !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_fast_c1: start=%b busy=%b stall=%b want 0 1 1", div_bus.div_start, busy, stall_req);
        end
        last_result = {32'd5, 32'hFFFF_FFFF};
        tick(); // cycle 2
`else
        vectors++;
        if (div_bus.div_start !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_slow_start: start=%b want 1", div_bus.div_start);
        end
        tick(); // cycle 2
        div_bus.div_ready = 1'b1; div_bus.div_result = 64'h0000_000A_0000_000B;
        last_result = 64'h0000_000A_0000_000B;
        tick(); // cycle 3
        div_bus.div_ready = 1'b0; #1;
`endif
        vectors++;
        if (result_valid !== 1'b1 || result !== last_result || stall_req !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_result: valid=%b result=%h stall=%b want 1 %h 0",
                     result_valid, result, stall_req, last_result);
        end
        tick();
        op = OP_NOP;
    endtask

    // Directed test 6: div_ready and flush in the same cycle. The flush wins.
    task automatic test_ready_flush();
        op = OP_DIVU; opdata1 = 32'd9; opdata2 = 32'd4;
        tick(); tick(); // cycle 2
        div_bus.div_ready = 1'b1; div_bus.div_result = 64'h1111_2222_3333_4444;
        flush = 1'b1; op = OP_NOP;
        tick(); // cycle 3
        div_bus.div_ready = 1'b0; flush = 1'b0; #1;
        vectors++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== last_result || div_bus.div_annul !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_flush: busy=%b valid=%b result=%h annul=%b want 0 0 %h 1",
                     busy, result_valid, result, div_bus.div_annul, last_result);
        end
        tick();
    endtask

    // A divide op that arrives together with a flush must not start the divider.
    task automatic test_flush_idle();
        op = OP_DIV; opdata1 = 32'd8; opdata2 = 32'd2; flush = 1'b1; #1;
        vectors++;
        if (stall_req !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle_stall: stall=%b want 0", stall_req);
        end
        tick();
        vectors++;
        if (div_bus.div_start !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle_start: start=%b busy=%b want 0 0", div_bus.div_start, busy);
        end
        flush = 1'b0; op = OP_NOP;
        tick();
    endtask

    // Two divisions issued back to back. The second one follows the release cycle.
    task automatic test_back_to_back();
        op = OP_DIVU; opdata1 = 32'd9; opdata2 = 32'd4;
        tick(); tick(); // cycle 2
        div_bus.div_ready = 1'b1; div_bus.div_result = {32'd1, 32'd2};
        tick(); // cycle 3, DONE
        div_bus.div_ready = 1'b0;
        tick(); // cycle 4, IDLE with the next op
        op = OP_DIVU; opdata1 = 32'd15; opdata2 = 32'd4; #1;
        vectors++;
        if (stall_req !== 1'b1 || result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second_op: stall=%b valid=%b want 1 0", stall_req, result_valid);
        end
        tick(); // cycle 5
        vectors++;
        if (div_bus.div_start !== 1'b1 || div_bus.div_opdata1 !== 32'd15) begin
            miscompares++;
            $display("FAIL b2b_second_start: start=%b op1=%0d want 1 15", div_bus.div_start, div_bus.div_opdata1);
        end
        div_bus.div_ready = 1'b1; div_bus.div_result = {32'd3, 32'd3};
        tick(); // cycle 6
        div_bus.div_ready = 1'b0; #1;
        last_result = {32'd3, 32'd3};
        vectors++;
        if (result_valid !== 1'b1 || result !== last_result) begin
            miscompares++;
            $display("FAIL b2b_second_result: valid=%b result=%h want 1 %h", result_valid, result, last_result);
        end
        tick();
        op = OP_NOP;
        tick();
    endtask

    // A reset in the middle of an operation clears everything at once.
    task automatic test_reset_mid();
        op = OP_DIV; opdata1 = 32'd1; opdata2 = 32'd1;
        tick(); tick();
        op = OP_NOP; rst_n = 1'b0; #1;
        vectors++;
        if (busy !== 1'b0 || div_bus.div_start !== 1'b0 || result_valid !== 1'b0 || result !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b start=%b valid=%b result=%h want 0 0 0 0",
                     busy, div_bus.div_start, result_valid, result);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_flush_run();
        test_ex_stall_hold();
        test_zero_divisor();
        test_ready_flush();
        test_flush_idle();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
